// File: rtl/axi4_lite_mon_pkg.sv
// Shared definitions for the AXI4-Lite protocol monitor: check IDs, response codes
// and the lowest-ID priority encoder used for first-error capture.
package axi4_lite_mon_pkg;

    typedef enum logic [3:0] {
        CHK_AW_STAB      = 4'd0,
        CHK_W_STAB       = 4'd1,
        CHK_B_STAB       = 4'd2,
        CHK_AR_STAB      = 4'd3,
        CHK_R_STAB       = 4'd4,
        CHK_ADDR_ALIGN   = 4'd5,
        CHK_RESP_ILLEGAL = 4'd6,
        CHK_B_ORPHAN     = 4'd7,
        CHK_R_ORPHAN     = 4'd8,
        CHK_TIMEOUT      = 4'd9,
        CHK_OUTST_OVF    = 4'd10
    } chk_id_e;

    localparam int NUM_CHK = 11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [3:0] lowest_id(input logic [NUM_CHK-1:0] v);
        logic [3:0] id;
        id = 4'd0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (v[i]) id = 4'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/axi4_lite_chan_watch.sv
// Per-channel watcher: flags payload/valid changes during a stall and pulses once
// when a single stall lasts TIMEOUT cycles (TIMEOUT = 0 disables the timeout).
module axi4_lite_chan_watch #(
    parameter int PAYLOAD_W = 32,
    parameter int TIMEOUT   = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic                 ready,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 stab_err,
    output logic                 timeout
);

    logic                 stall;
    logic                 stall_reg;
    logic [PAYLOAD_W-1:0] payload_reg;

    assign stall = valid & ~ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_reg   <= 1'b0;
            payload_reg <= '0;
        end else begin
            stall_reg   <= stall;
            payload_reg <= payload;
        end
    end

    assign stab_err = stall_reg & (~valid | (payload != payload_reg));

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign timeout = 1'b0;
        end else begin : g_timeout
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
            localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] cnt_reg;

            // Counter saturates at LIMIT, so the LAST match happens only once per stall.
            always_ff @(posedge clk) begin
                if (rst || !stall) begin
                    cnt_reg <= '0;
                end else if (cnt_reg != LIMIT) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign timeout = stall & (cnt_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/axi4_lite_protocol_monitor.sv
// Passive AXI4-Lite protocol checker with sticky/pulse flags, error count and first-error ID.
// Define AXI_LITE_MON_SVA_EN to add one simulation-only assertion per check ID.
module axi4_lite_protocol_monitor
    import axi4_lite_mon_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter logic [3:0] RESP_MASK = 4'b0011,
    parameter int         TIMEOUT   = 256,
    parameter int         MAX_OUTST = 4,
    parameter int         ERR_CNT_W = 16,
    localparam int        STRB_W    = DATA_W / 8,
    localparam int        OW        = $clog2(MAX_OUTST + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 awvalid,
    input  logic                 awready,
    input  logic [ADDR_W-1:0]    awaddr,
    input  logic                 wvalid,
    input  logic                 wready,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [STRB_W-1:0]    wstrb,
    input  logic                 bvalid,
    input  logic                 bready,
    input  logic [1:0]           bresp,
    input  logic                 arvalid,
    input  logic                 arready,
    input  logic [ADDR_W-1:0]    araddr,
    input  logic                 rvalid,
    input  logic                 rready,
    input  logic [DATA_W-1:0]    rdata,
    input  logic [1:0]           rresp,
    output logic [NUM_CHK-1:0]   err_sticky,
    output logic [NUM_CHK-1:0]   err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_err_valid,
    output logic [3:0]           first_err_id,
    output logic [OW-1:0]        wr_outst,
    output logic [OW-1:0]        rd_outst
);

    localparam int MAXW = (ADDR_W > DATA_W + STRB_W) ? ADDR_W : DATA_W + STRB_W;
    localparam int AL   = $clog2(STRB_W);
    localparam logic [OW-1:0] OUTST_MAX  = OW'(MAX_OUTST);
    localparam logic [OW-1:0] OUTST_HOLD = OW'(MAX_OUTST + 1);

    // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R (matches the stability check IDs).
    logic [4:0]            chan_valid;
    logic [4:0]            chan_ready;
    logic [4:0][MAXW-1:0]  chan_payload;
    logic [4:0]            chan_stab;
    logic [4:0]            chan_to;

    assign chan_valid      = {rvalid, arvalid, bvalid, wvalid, awvalid};
    assign chan_ready      = {rready, arready, bready, wready, awready};
    assign chan_payload[0] = MAXW'(awaddr);
    assign chan_payload[1] = MAXW'({wstrb, wdata});
    assign chan_payload[2] = MAXW'(bresp);
    assign chan_payload[3] = MAXW'(araddr);
    assign chan_payload[4] = MAXW'({rresp, rdata});

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_chan
            axi4_lite_chan_watch #(
                .PAYLOAD_W (MAXW),
                .TIMEOUT   (TIMEOUT)
            ) u_watch (
                .clk      (clk),
                .rst      (rst),
                .valid    (chan_valid[gi]),
                .ready    (chan_ready[gi]),
                .payload  (chan_payload[gi]),
                .stab_err (chan_stab[gi]),
                .timeout  (chan_to[gi])
            );
        end
    endgenerate

    // Pending counters: 0 AW, 1 W (both retired by B), 2 AR (retired by R).
    logic [2:0]          pend_inc;
    logic [2:0]          pend_dec;
    logic [2:0]          pend_ovf;
    logic [2:0][OW-1:0]  pend;

    assign pend_inc = {arvalid & arready, wvalid & wready, awvalid & awready};
    assign pend_dec = {rvalid & rready, bvalid & bready, bvalid & bready};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_pend
            logic [OW-1:0] cnt_reg;
            logic          dec_ok;

            assign dec_ok       = pend_dec[gi] & (cnt_reg != '0);
            assign pend_ovf[gi] = pend_inc[gi] & ~dec_ok & (cnt_reg >= OUTST_MAX);
            assign pend[gi]     = cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (pend_inc[gi] && !dec_ok && cnt_reg != OUTST_HOLD) begin
                    cnt_reg <= cnt_reg + OW'(1);
                end else if (!pend_inc[gi] && dec_ok) begin
                    cnt_reg <= cnt_reg - OW'(1);
                end
            end
        end
    endgenerate

    logic [NUM_CHK-1:0] viol;
    logic               any_viol;

    always_comb begin
        viol                   = '0;
        viol[4:0]              = chan_stab;
        viol[CHK_ADDR_ALIGN]   = (awvalid & (awaddr[AL-1:0] != '0)) |
                                 (arvalid & (araddr[AL-1:0] != '0));
        viol[CHK_RESP_ILLEGAL] = (bvalid & ~RESP_MASK[bresp]) | (rvalid & ~RESP_MASK[rresp]);
        // Orphan checks use the registered (pre-edge) pending counts.
        viol[CHK_B_ORPHAN]     = bvalid & ((pend[0] == '0) | (pend[1] == '0));
        viol[CHK_R_ORPHAN]     = rvalid & (pend[2] == '0);
        viol[CHK_TIMEOUT]      = |chan_to;
        viol[CHK_OUTST_OVF]    = |pend_ovf;
    end

    assign any_viol = |viol;

    logic [NUM_CHK-1:0]   err_pulse_reg;
    logic [NUM_CHK-1:0]   err_sticky_reg;
    logic [ERR_CNT_W-1:0] err_count_reg;
    logic                 first_err_valid_reg;
    logic [3:0]           first_err_id_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse_reg       <= '0;
            err_sticky_reg      <= '0;
            err_count_reg       <= '0;
            first_err_valid_reg <= 1'b0;
            first_err_id_reg    <= 4'd0;
        end else begin
            err_pulse_reg <= viol;
            // A violation coinciding with clear is loaded fresh rather than lost.
            if (clear) begin
                err_sticky_reg      <= viol;
                err_count_reg       <= any_viol ? ERR_CNT_W'(1) : '0;
                first_err_valid_reg <= any_viol;
                first_err_id_reg    <= any_viol ? lowest_id(viol) : 4'd0;
            end else begin
                err_sticky_reg <= err_sticky_reg | viol;
                if (any_viol && err_count_reg != '1) begin
                    err_count_reg <= err_count_reg + ERR_CNT_W'(1);
                end
                if (any_viol && !first_err_valid_reg) begin
                    first_err_valid_reg <= 1'b1;
                    first_err_id_reg    <= lowest_id(viol);
                end
            end
        end
    end

    assign err_pulse       = err_pulse_reg;
    assign err_sticky      = err_sticky_reg;
    assign err_count       = err_count_reg;
    assign first_err_valid = first_err_valid_reg;
    assign first_err_id    = first_err_id_reg;
    assign wr_outst        = pend[0];
    assign rd_outst        = pend[2];

`ifdef AXI_LITE_MON_SVA_EN
    generate
        for (gi = 0; gi < NUM_CHK; gi++) begin : g_sva
            a_chk : assert property (@(posedge clk) disable iff (rst) !viol[gi])
                else $error("axi4-lite check %0d violated: awaddr=%h wdata=%h wstrb=%h bresp=%0d araddr=%h rdata=%h rresp=%0d wr_outst=%0d rd_outst=%0d",
                            gi, awaddr, wdata, wstrb, bresp, araddr, rdata, rresp, pend[0], pend[2]);
        end
    endgenerate
`endif

endmodule

// File: tb/tb_axi4_lite_protocol_monitor.sv
// Scoreboard bench for axi4_lite_protocol_monitor: directed per-cycle vectors push
// hand-computed expectations; a monitor process pops and compares after each edge.
module tb_axi4_lite_protocol_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    logic [10:0] err_sticky, err_pulse;
    logic [15:0] err_count;
    logic        first_err_valid;
    logic [3:0]  first_err_id;
    logic [1:0]  wr_outst, rd_outst;

    logic [10:0] err_sticky2, err_pulse2;
    logic [15:0] err_count2;
    logic        first_err_valid2;
    logic [3:0]  first_err_id2;
    logic [1:0]  wr_outst2, rd_outst2;

    axi4_lite_protocol_monitor #(
        .ADDR_W(32), .DATA_W(32), .RESP_MASK(4'b0011), .TIMEOUT(8), .MAX_OUTST(2), .ERR_CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .err_sticky(err_sticky), .err_pulse(err_pulse), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_id(first_err_id),
        .wr_outst(wr_outst), .rd_outst(rd_outst)
    );

    // Same stimulus, SLVERR made legal: only the response check should differ.
    axi4_lite_protocol_monitor #(
        .ADDR_W(32), .DATA_W(32), .RESP_MASK(4'b0111), .TIMEOUT(8), .MAX_OUTST(2), .ERR_CNT_W(16)
    ) dut_mask (
        .clk(clk), .rst(rst), .clear(clear),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .err_sticky(err_sticky2), .err_pulse(err_pulse2), .err_count(err_count2),
        .first_err_valid(first_err_valid2), .first_err_id(first_err_id2),
        .wr_outst(wr_outst2), .rd_outst(rd_outst2)
    );

    typedef struct {
        string       name;
        int          tgt;
        logic [10:0] pulse;
        logic [10:0] sticky;
        logic [15:0] count;
        logic        fev;
        logic [3:0]  fid;
        logic [1:0]  wr;
        logic [1:0]  rd;
        logic [10:0] pulse2;
    } exp_t;

    exp_t sb[$];
    int   edges       = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            edges = edges + 1;
            while (sb.size() > 0 && sb[0].tgt < edges) begin
                exp_t m;
                m = sb.pop_front();
                miscompares++;
                $display("FAIL %s: expectation for edge %0d was never compared", m.name, m.tgt);
            end
            if (sb.size() > 0 && sb[0].tgt == edges) begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                if (err_pulse !== e.pulse || err_sticky !== e.sticky || err_count !== e.count ||
                    first_err_valid !== e.fev || first_err_id !== e.fid ||
                    wr_outst !== e.wr || rd_outst !== e.rd || err_pulse2 !== e.pulse2) begin
                    miscompares++;
                    $display("FAIL %s (got/want): pulse=%h/%h sticky=%h/%h count=%0d/%0d fev=%0b/%0b fid=%0d/%0d wr=%0d/%0d rd=%0d/%0d pulse_mask0111=%h/%h",
                             e.name, err_pulse, e.pulse, err_sticky, e.sticky, err_count, e.count,
                             first_err_valid, e.fev, first_err_id, e.fid, wr_outst, e.wr,
                             rd_outst, e.rd, err_pulse2, e.pulse2);
                end else begin
                    $display("ok   %-16s pulse=%h sticky=%h count=%0d first=%0b/%0d wr=%0d rd=%0d",
                             e.name, err_pulse, err_sticky, err_count, first_err_valid,
                             first_err_id, wr_outst, rd_outst);
                end
            end
        end
    end

    task automatic step_x(input string name, input logic [10:0] pulse, input logic [10:0] sticky,
                          input logic [15:0] count, input logic fev, input logic [3:0] fid,
                          input logic [1:0] wr, input logic [1:0] rd, input logic p6_mask);
        exp_t e;
        e.name   = name;
        e.tgt    = edges + 1;
        e.pulse  = pulse;
        e.sticky = sticky;
        e.count  = count;
        e.fev    = fev;
        e.fid    = fid;
        e.wr     = wr;
        e.rd     = rd;
        e.pulse2 = pulse;
        e.pulse2[6] = p6_mask;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic step(input string name, input logic [10:0] pulse, input logic [10:0] sticky,
                        input logic [15:0] count, input logic fev, input logic [3:0] fid,
                        input logic [1:0] wr, input logic [1:0] rd);
        step_x(name, pulse, sticky, count, fev, fid, wr, rd, pulse[6]);
    endtask

    task automatic idle();
        clear = 0;
        awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
        arvalid = 0; arready = 0; rvalid = 0; rready = 0;
        bresp = 2'b00; rresp = 2'b00; wstrb = 4'h0;
    endtask

    initial begin
        awaddr = 0; araddr = 0; wdata = 0; rdata = 0;
        rst = 1;
        idle();
        step("reset0", 11'h000, 11'h000, 0, 0, 0, 0, 0);
        step("reset1", 11'h000, 11'h000, 0, 0, 0, 0, 0);
        rst = 0;

        // AW stall with address change on the 4th cycle
        awvalid = 1; awaddr = 32'h10;
        for (int i = 0; i < 3; i++) step("aw_stall", 11'h000, 11'h000, 0, 0, 0, 0, 0);
        awaddr = 32'h14;
        step("aw_stab", 11'h001, 11'h001, 1, 1, 0, 0, 0);
        awready = 1;
        step("aw_accept", 11'h000, 11'h001, 1, 1, 0, 1, 0);
        idle(); wvalid = 1; wready = 1; wdata = 32'hdead_beef; wstrb = 4'hf;
        step("w_accept", 11'h000, 11'h001, 1, 1, 0, 1, 0);
        idle(); bvalid = 1; bready = 1;
        step("b_accept", 11'h000, 11'h001, 1, 1, 0, 0, 0);

        // B in the same cycle as the AW/W handshakes is orphaned
        idle(); awvalid = 1; awready = 1; awaddr = 32'h20; wvalid = 1; wready = 1; wstrb = 4'hf;
        bvalid = 1;
        step("b_orphan", 11'h080, 11'h081, 2, 1, 0, 1, 0);
        idle(); bvalid = 1; bready = 1;
        step("b_after", 11'h000, 11'h081, 2, 1, 0, 0, 0);

        // SLVERR illegal under 4'b0011, legal under 4'b0111
        idle(); awvalid = 1; awready = 1; awaddr = 32'h30; wvalid = 1; wready = 1; wstrb = 4'h3;
        step("wr_pair", 11'h000, 11'h081, 2, 1, 0, 1, 0);
        idle(); bvalid = 1; bready = 1; bresp = 2'b10;
        step_x("bresp_slverr", 11'h040, 11'h0C1, 3, 1, 0, 0, 0, 1'b0);

        // AR stall of 20 cycles: single timeout pulse after the 8th stalled cycle
        idle(); arvalid = 1; araddr = 32'h40;
        for (int k = 1; k <= 20; k++) begin
            if (k < 8)       step("ar_stall", 11'h000, 11'h0C1, 3, 1, 0, 0, 0);
            else if (k == 8) step("ar_timeout", 11'h200, 11'h2C1, 4, 1, 0, 0, 0);
            else             step("ar_stall_sat", 11'h000, 11'h2C1, 4, 1, 0, 0, 0);
        end
        arready = 1;
        step("ar_accept", 11'h000, 11'h2C1, 4, 1, 0, 0, 1);
        araddr = 32'h44;
        step("ar_2", 11'h000, 11'h2C1, 4, 1, 0, 0, 2);
        araddr = 32'h48;
        step("ar_ovf", 11'h400, 11'h6C1, 5, 1, 0, 0, 3);
        araddr = 32'h4C;
        step("ar_ovf_hold", 11'h400, 11'h6C1, 6, 1, 0, 0, 3);

        // Drain reads, one with DECERR (illegal for both masks), then an orphan R
        idle(); rvalid = 1; rready = 1; rdata = 32'h1234_5678;
        step("r_1", 11'h000, 11'h6C1, 6, 1, 0, 0, 2);
        rresp = 2'b11;
        step("rresp_decerr", 11'h040, 11'h6C1, 7, 1, 0, 0, 1);
        rresp = 2'b00;
        step("r_3", 11'h000, 11'h6C1, 7, 1, 0, 0, 0);
        step("r_orphan", 11'h100, 11'h7C1, 8, 1, 0, 0, 0);

        // clear together with a misaligned AR, then clear alone
        idle(); clear = 1; arvalid = 1; arready = 1; araddr = 32'h2;
        step("clear_align", 11'h020, 11'h020, 1, 1, 5, 0, 1);
        idle(); clear = 1;
        step("clear_only", 11'h000, 11'h000, 0, 0, 0, 0, 1);
        idle(); rvalid = 1; rready = 1;
        step("r_drain", 11'h000, 11'h000, 0, 0, 0, 0, 0);

        // Reset during a stalled, misaligned AW
        idle(); awvalid = 1; awaddr = 32'h51;
        step("aw_misalign1", 11'h020, 11'h020, 1, 1, 5, 0, 0);
        step("aw_misalign2", 11'h020, 11'h020, 2, 1, 5, 0, 0);
        rst = 1; awvalid = 0;
        step("rst_mid_stall", 11'h000, 11'h000, 0, 0, 0, 0, 0);
        rst = 0; awvalid = 1; awaddr = 32'h54;
        step("post_rst", 11'h000, 11'h000, 0, 0, 0, 0, 0);
        awready = 1;
        step("post_rst_acc", 11'h000, 11'h000, 0, 0, 0, 1, 0);
        idle();
        step("idle_end", 11'h000, 11'h000, 0, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d expectations left, want 0", sb.size());
        end
        $display("mask0111 instance final: count=%0d sticky=%h first=%0b/%0d wr=%0d rd=%0d",
                 err_count2, err_sticky2, first_err_valid2, first_err_id2, wr_outst2, rd_outst2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
